adc_reader_ad760x: RTL and testbench

Parametrised successor to the fixed 8-channel AD7608 serial reader. Drives CONVST/CS/SCLK-enable of an AD760x-family simultaneous-sampling ADC, deserialises N parallel DOUT lines and delivers one DATA_BITS word per channel with a per-channel ready mask. Adds synchronous reset, triggered or free-running mode, busy-timeout recovery and trigger-overrun detection. Sits between the ADC pins and the per-channel consumers (pulse-sequencer readback, data FIFOs).

---
 rtl/adc_reader_ad760x_pkg.sv | 22 ++
 rtl/adc_reader_ad760x_serial_deser.sv | 31 +++
 rtl/adc_reader_ad760x.sv | 154 +++++++++++++++
 tb/tb_adc_reader_ad760x.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_reader_ad760x_pkg.sv
// Shared state encoding and sizing helpers for the AD760x serial reader.
package adc_reader_pkg;

  typedef enum logic [2:0] {
    IDLE, CONVST, WAIT_HI, WAIT_LO, READ_SETUP, READ, DELIVER
  } state_e;

  // Channels carried by each DOUT line.
  function automatic int calc_cpl(input int nchan, input int lines);
    return nchan / lines;
  endfunction

  // Serial bits clocked out on each DOUT line per conversion.
  function automatic int calc_bits(input int nchan, input int lines, input int sample_bits);
    return calc_cpl(nchan, lines) * sample_bits;
  endfunction

  function automatic int calc_cnt_w(input int bits, input int timeout);
    return $clog2(((bits > timeout) ? bits : timeout) + 1);
  endfunction

endpackage

// File: rtl/adc_reader_ad760x_serial_deser.sv
// One DOUT line: negedge shift register split into per-channel words,
// keeping the top DATA_BITS of each SAMPLE_BITS sample.
module adc_serial_deser
  import adc_reader_pkg::*;
#(
  parameter int CPL         = 4,
  parameter int SAMPLE_BITS = 18,
  parameter int DATA_BITS   = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            shift_en_i,
  input  logic                            din_i,
  output logic [CPL-1:0][DATA_BITS-1:0]   words_o
);

  localparam int BITS = calc_bits(CPL, 1, SAMPLE_BITS);

  logic [BITS-1:0] sr_q;

  always_ff @(negedge clk_i) begin
    if (rst_i)           sr_q <= '0;
    else if (shift_en_i) sr_q <= {sr_q[BITS-2:0], din_i};
  end

  // The first sample shifted in (lowest channel) ends up in the top slice.
  for (genvar j = 0; j < CPL; j++) begin : g_word
    assign words_o[j] = sr_q[BITS-1-j*SAMPLE_BITS -: DATA_BITS];
  end

endmodule

// File: rtl/adc_reader_ad760x.sv
// AD760x-family reader: CONVST/BUSY handshake, parallel serial readout on
// DOUT_LINES lines, per-channel delivery with busy timeout and overrun flags.
module adc_reader_ad760x
  import adc_reader_pkg::*;
#(
  parameter int NCHAN        = 8,
  parameter int DOUT_LINES   = 2,
  parameter int SAMPLE_BITS  = 18,
  parameter int DATA_BITS    = 16,
  parameter int CONVST_LOW   = 1,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NCHAN-1:0]            adc_enable_i,
  input  logic                        free_run_i,
  input  logic                        trigger_i,
  output logic [NCHAN*DATA_BITS-1:0]  adcdata_o,
  output logic [NCHAN-1:0]            adcready_o,
  output logic                        cs_o,
  output logic                        convst_o,
  input  logic [DOUT_LINES-1:0]       adc_dout_i,
  input  logic                        adc_busy_i,
  output logic                        sclk_enable_o,
  output logic                        timeout_err_o,
  output logic                        overrun_o
);

  localparam int CPL  = calc_cpl(NCHAN, DOUT_LINES);
  localparam int BITS = calc_bits(NCHAN, DOUT_LINES, SAMPLE_BITS);
  localparam int CW   = calc_cnt_w(BITS, BUSY_TIMEOUT);

  localparam logic [CW-1:0] BITS_C   = CW'(BITS);
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CL_LAST  = CW'(CONVST_LOW - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if ((NCHAN % DOUT_LINES) != 0 || DATA_BITS > SAMPLE_BITS || CONVST_LOW < 1) begin : g_bad_param
    $error("adc_reader_ad760x: illegal parameter combination");
  end

  state_e                          state_q;
  logic [CW-1:0]                   cnt_q;
  logic                            cs_q, convst_q, sclk_q, to_q, ovr_q;
  logic [NCHAN-1:0]                rdy_q;
  logic [NCHAN-1:0][DATA_BITS-1:0] data_q, data_d;
  logic [DOUT_LINES-1:0][CPL-1:0][DATA_BITS-1:0] words;

  for (genvar k = 0; k < DOUT_LINES; k++) begin : g_line
    adc_serial_deser #(
      .CPL         (CPL),
      .SAMPLE_BITS (SAMPLE_BITS),
      .DATA_BITS   (DATA_BITS)
    ) u_deser (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .shift_en_i (~cs_q),
      .din_i      (adc_dout_i[k]),
      .words_o    (words[k])
    );
  end

  // Line k carries channels k*CPL .. k*CPL+CPL-1.
  for (genvar c = 0; c < NCHAN; c++) begin : g_map
    assign data_d[c] = words[c / CPL][c % CPL];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cs_q     <= 1'b1;
      convst_q <= 1'b1;
      sclk_q   <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
      rdy_q    <= '0;
      data_q   <= '0;
    end else begin
      to_q  <= 1'b0;
      rdy_q <= '0;
      ovr_q <= trigger_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (free_run_i || trigger_i) begin
            state_q  <= CONVST;
            convst_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        CONVST: begin
          if (cnt_q == CL_LAST) begin
            convst_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= WAIT_HI;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_HI: begin
          if (adc_busy_i) begin
            cnt_q   <= '0;
            state_q <= WAIT_LO;
          end else if (cnt_q == TO_LAST) begin
            to_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!adc_busy_i) begin
            state_q <= READ_SETUP;
          end else if (cnt_q == TO_LAST) begin
            to_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READ_SETUP: begin
          cs_q    <= 1'b0;
          sclk_q  <= 1'b1;
          cnt_q   <= BITS_C;
          state_q <= READ;
        end
        READ: begin
          cnt_q <= cnt_q - 1'b1;
          // Closing on count 1 keeps SCLK enabled for exactly BITS cycles.
          if (cnt_q == CNT_ONE) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            state_q <= DELIVER;
          end
        end
        DELIVER: begin
          data_q  <= data_d;
          rdy_q   <= adc_enable_i;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adcdata_o     = data_q;
  assign adcready_o    = rdy_q;
  assign cs_o          = cs_q;
  assign convst_o      = convst_q;
  assign sclk_enable_o = sclk_q;
  assign timeout_err_o = to_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_adc_reader_ad760x.sv
// Scoreboard bench: dut0 = AD7608 defaults, dut1 = AD7606 single-line with short timeout.
module tb_adc_reader_ad760x;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, fr0, fr1, trg0, trg1;
  logic [7:0] en0, en1, rdy0, rdy1;
  logic [127:0] data0, data1;
  logic cs0, cs1, cv0, cv1, sclk0, sclk1, to0, to1, ovr0, ovr1;
  logic [1:0] dout0;
  logic [0:0] dout1;
  logic busy0 = 1'b0, busy1 = 1'b0;
  logic busy_on0, busy_on1;
  logic [7:0][17:0] w0;
  logic [7:0][15:0] w1;
  int bcnt0 = 0, bcnt1 = 0, bit0 = 0, bit1 = 0;

  typedef struct packed { logic [127:0] d; logic [7:0] r; } exp_t;
  exp_t q0[$], q1[$];
  int tests = 0, fails = 0;
  int deliv0 = 0, deliv1 = 0, sclk0_n = 0, sclk1_n = 0, cslo0_n = 0, ovr0_n = 0, to1_n = 0;

  adc_reader_ad760x #(.NCHAN(8), .DOUT_LINES(2), .SAMPLE_BITS(18), .DATA_BITS(16),
                      .CONVST_LOW(1), .BUSY_TIMEOUT(4096)) dut0 (
    .clk_i(clk), .rst_i(rst0), .adc_enable_i(en0), .free_run_i(fr0), .trigger_i(trg0),
    .adcdata_o(data0), .adcready_o(rdy0), .cs_o(cs0), .convst_o(cv0), .adc_dout_i(dout0),
    .adc_busy_i(busy0), .sclk_enable_o(sclk0), .timeout_err_o(to0), .overrun_o(ovr0));

  adc_reader_ad760x #(.NCHAN(8), .DOUT_LINES(1), .SAMPLE_BITS(16), .DATA_BITS(16),
                      .CONVST_LOW(1), .BUSY_TIMEOUT(16)) dut1 (
    .clk_i(clk), .rst_i(rst1), .adc_enable_i(en1), .free_run_i(fr1), .trigger_i(trg1),
    .adcdata_o(data1), .adcready_o(rdy1), .cs_o(cs1), .convst_o(cv1), .adc_dout_i(dout1),
    .adc_busy_i(busy1), .sclk_enable_o(sclk1), .timeout_err_o(to1), .overrun_o(ovr1));

  // ADC model: BUSY a few cycles after CONVST, serial bits indexed by SCLK count.
  always @(posedge clk) begin
    if (cv0 == 1'b0) bcnt0 <= 1; else if (bcnt0 != 0) bcnt0 <= bcnt0 + 1;
    if (cv1 == 1'b0) bcnt1 <= 1; else if (bcnt1 != 0) bcnt1 <= bcnt1 + 1;
    busy0 <= busy_on0 && bcnt0 >= 3 && bcnt0 < 23;
    busy1 <= busy_on1 && bcnt1 >= 3 && bcnt1 < 13;
    bit0  <= (cs0 == 1'b0) ? bit0 + 1 : 0;
    bit1  <= (cs1 == 1'b0) ? bit1 + 1 : 0;
  end

  function automatic logic pick0(input logic [7:0][17:0] w, input int k, input int b);
    if (b < 0 || b >= 72) return 1'b0;
    return w[k*4 + b/18][17 - b%18];
  endfunction
  function automatic logic pick1(input logic [7:0][15:0] w, input int b);
    if (b < 0 || b >= 128) return 1'b0;
    return w[b/16][15 - b%16];
  endfunction

  assign dout0[0] = pick0(w0, 0, bit0);
  assign dout0[1] = pick0(w0, 1, bit0);
  assign dout1[0] = pick1(w1, bit1);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every adcready pulse.
  always @(negedge clk) begin
    if (sclk0 === 1'b1) sclk0_n++;
    if (cs0 === 1'b0)   cslo0_n++;
    if (ovr0 === 1'b1)  ovr0_n++;
    if (sclk1 === 1'b1) sclk1_n++;
    if (to1 === 1'b1)   to1_n++;
    if (rdy0 !== 8'd0 && !$isunknown(rdy0)) begin
      exp_t e;
      deliv0++;
      if (q0.size() == 0) chk("dut0 unexpected adcready", 128'(rdy0), 128'd0);
      else begin
        e = q0.pop_front();
        chk("dut0 adcdata", data0, e.d);
        chk("dut0 adcready", 128'(rdy0), 128'(e.r));
      end
    end
    if (rdy1 !== 8'd0 && !$isunknown(rdy1)) begin
      exp_t e;
      deliv1++;
      if (q1.size() == 0) chk("dut1 unexpected adcready", 128'(rdy1), 128'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 adcdata", data1, e.d);
        chk("dut1 adcready", 128'(rdy1), 128'(e.r));
      end
    end
  end

  task automatic wait_rdy(input int dut, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((dut == 0) ? rdy0 : rdy1) == 8'd0 && n < 1000);
    chki(nm, int'(((dut == 0) ? rdy0 : rdy1) != 8'd0), 1);
  endtask

  task automatic pulse(input int dut);
    if (dut == 0) trg0 = 1'b1; else trg1 = 1'b1;
    @(negedge clk);
    trg0 = 1'b0;
    trg1 = 1'b0;
  endtask

  initial begin
    int s, c, d, o, n;
    rst0 = 1'b1; rst1 = 1'b1; fr0 = 1'b0; fr1 = 1'b0; trg0 = 1'b0; trg1 = 1'b0;
    en0 = 8'hFF; en1 = 8'h0F; busy_on0 = 1'b1; busy_on1 = 1'b1;
    w0 = {18'h1234C, 18'h1234B, 18'h1234A, 18'h12349, 18'h12348, 18'h12347, 18'h00003, 18'h3FFFF};
    w1 = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'hDEAD, 16'hBEEF, 16'h8001, 16'h1234};
    repeat (3) @(negedge clk);

    chk("reset adcdata dut0", data0, 128'd0);
    chki("reset adcready dut0", int'(rdy0), 0);
    chki("reset ctrl dut0", int'({cs0, cv0, sclk0, to0, ovr0}), 5'b11000);
    chki("reset ctrl dut1", int'({cs1, cv1, sclk1, to1, ovr1}), 5'b11000);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // Triggered AD7608 conversion on two lines
    q0.push_back('{d: {16'h48D3, 16'h48D2, 16'h48D2, 16'h48D2, 16'h48D2, 16'h48D1, 16'h0000, 16'hFFFF},
                   r: 8'hFF});
    s = sclk0_n; c = cslo0_n;
    pulse(0);
    wait_rdy(0, "t1 wait adcready");
    repeat (2) @(negedge clk);
    chki("t1 sclk_enable cycles", sclk0_n - s, 72);
    chki("t1 cs low negedges", cslo0_n - c, 72);
    chki("t1 no overrun", ovr0_n, 0);

    // AD7606 mode, one line, partial enable
    q1.push_back('{d: w1, r: 8'h0F});
    s = sclk1_n;
    pulse(1);
    wait_rdy(1, "t2 wait adcready");
    @(negedge clk);
    chki("t2 sclk_enable cycles", sclk1_n - s, 128);

    // Busy never rises -> timeout, then a normal conversion
    busy_on1 = 1'b0;
    d = deliv1; o = to1_n;
    pulse(1);
    n = 0;
    while (cv1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (to1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chki("t3 timeout latency", n, 16);
    repeat (40) @(negedge clk);
    chki("t3 timeout pulses", to1_n - o, 1);
    chki("t3 no delivery", deliv1 - d, 0);
    busy_on1 = 1'b1; en1 = 8'hA5;
    w1 = {16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16'h1357, 16'h2468, 16'hACE1, 16'h8642};
    q1.push_back('{d: w1, r: 8'hA5});
    pulse(1);
    wait_rdy(1, "t3 recovery adcready");

    // Free-run: three conversions, trigger mid-READ flagged as overrun
    w0 = {18'h3C000, 18'h00004, 18'h10001, 18'h2FFFF, 18'h00010, 18'h3F00F, 18'h0ABCD, 18'h1E001};
    for (int i = 0; i < 3; i++)
      q0.push_back('{d: {16'hF000, 16'h0001, 16'h4000, 16'hBFFF, 16'h0004, 16'hFC03, 16'h2AF3, 16'h7800},
                     r: 8'hFF});
    d = deliv0; o = ovr0_n;
    fr0 = 1'b1;
    wait_rdy(0, "t4 adcready 1");
    @(negedge clk);
    chki("t4 idle one cycle after 1st", int'(cv0), 0);
    n = 0;
    while (sclk0 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    pulse(0);
    chki("t4 overrun pulse", int'(ovr0), 1);
    @(negedge clk);
    chki("t4 overrun one cycle", int'(ovr0), 0);
    wait_rdy(0, "t4 adcready 2");
    @(negedge clk);
    chki("t4 idle one cycle after 2nd", int'(cv0), 0);
    fr0 = 1'b0;
    wait_rdy(0, "t4 adcready 3");
    repeat (200) @(negedge clk);
    chki("t4 conversion count", deliv0 - d, 3);
    chki("t4 overrun count", ovr0_n - o, 1);

    // Reset in the middle of READ
    s = sclk0_n; d = deliv0;
    pulse(0);
    n = 0;
    while (sclk0_n - s < 30 && n < 300) begin @(negedge clk); n++; end
    rst0 = 1'b1;
    @(negedge clk);
    chki("t5 cs/sclk after rst", int'({cs0, sclk0, cv0}), 3'b101);
    chk("t5 adcdata cleared", data0, 128'd0);
    chki("t5 adcready low", int'(rdy0), 0);
    rst0 = 1'b0;
    repeat (150) @(negedge clk);
    chki("t5 no delivery after abort", deliv0 - d, 0);
    w0 = {18'h00000, 18'h3FFFC, 18'h20000, 18'h1FFFF, 18'h15555, 18'h2AAAA, 18'h0C0C3, 18'h33330};
    q0.push_back('{d: {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h5555, 16'hAAAA, 16'h3030, 16'hCCCC},
                   r: 8'hFF});
    pulse(0);
    wait_rdy(0, "t5 clean conversion");
    repeat (5) @(negedge clk);

    chki("scoreboard dut0 drained", q0.size(), 0);
    chki("scoreboard dut1 drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
